// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out of the fetch unit, ack/data back from memory.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, imem req/ack fetch, next-PC selection and retired-instruction counter.
// Optional FETCH_MISALIGN_CHECK_EN halts on a misaligned next PC instead of forcing alignment.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        imem,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [6:0]                op,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  input  logic                      instr_ready,
  input  logic                      branch,
  input  logic                      jal,
  input  logic                      jalr,
  input  logic                      zero,
  input  logic [31:0]               branch_target,
  input  logic [31:0]               jalr_target,
  output logic [31:0]               retired,
  output logic                      misalign
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2, HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
`endif

  // jalr wins over jal/branch; its target always has bit 0 cleared
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (jalr) begin
      next_pc = jalr_target & ~32'h0000_0001;
    end else if (jal | (branch & zero)) begin
      next_pc = branch_target;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          instr_d   = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            state_d = REQ;
          end
`else
          pc_d    = next_pc & ~32'h0000_0003;
          state_d = REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == VALID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      retired_q     <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign op             = instr_q[6:0];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign retired        = retired_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign       = misalign_q;
`else
  assign misalign       = 1'b0;
`endif

endmodule
